code_nco_ctrl: RTL and testbench
================================

Name: code_nco_ctrl

Overview:
- Sequencing controller for one tracking channel's code DDS (phase-accumulator NCO). It drives the DDS `enable` and phase-increment inputs and watches the DDS output MSB.
- Counts code chips from rising edges of that MSB and emits an epoch strobe every CHIPS_PER_EPOCH chips.
- Applies loop-filter rate updates and code-phase slew requests only on epoch boundaries, so accumulation intervals stay aligned.
- Sits between the channel's tracking-loop register interface and its code DDS instance.

Parameters:
- PHASE_INC_WIDTH, 24, width of the DDS phase increment.
- CHIPS_PER_EPOCH, 1023, chips per code epoch (C/A code length).
- CHIP_CNT_WIDTH, 10, width of the chip counter; must satisfy 2^CHIP_CNT_WIDTH >= CHIPS_PER_EPOCH.
- SLEW_WIDTH, 11, width of the slew cycle count.
- INC_RESET_VALUE, 24'd0, DDS increment loaded at reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- inc_in  in  PHASE_INC_WIDTH  new code-rate increment.
- inc_valid  in  1  inc_in is valid.
- inc_ready  out  1  increment holding register is free.
- slew_cnt  in  SLEW_WIDTH  number of clk cycles to freeze the DDS.
- slew_valid  in  1  slew_cnt is valid.
- slew_ready  out  1  slew holding register is free.
- dds_msb  in  1  MSB of the DDS output (chip clock).
- dds_inc  out  PHASE_INC_WIDTH  increment driven to the DDS.
- dds_enable  out  1  DDS enable.
- epoch  out  1  one-cycle strobe at each epoch boundary.
- chip_cnt  out  CHIP_CNT_WIDTH  current chip index within the epoch.
- slewing  out  1  high while a slew is in progress.

Behaviour:
- Reset (synchronous, active-high, one clk):
  - dds_inc=INC_RESET_VALUE, dds_enable=1, epoch=0, chip_cnt=0, slewing=0.
  - Both holding registers are emptied and msb_prev is cleared.
  - Reset mid-slew aborts the slew; dds_enable is 1 the cycle after reset.
- Chip edge:
  - chip_edge = dds_msb & ~msb_prev, with msb_prev registered every cycle.
  - On chip_edge: chip_cnt increments, or wraps to 0 if it equals CHIPS_PER_EPOCH-1.
- Epoch:
  - epoch_hit = chip_edge & (chip_cnt == CHIPS_PER_EPOCH-1).
  - epoch is registered and goes high for the single cycle after epoch_hit.
- Increment handshake:
  - One-entry holding register; inc_ready = ~inc_pend.
  - Transfer occurs when inc_valid & inc_ready; inc_in is captured and inc_pend is set.
  - On epoch_hit with inc_pend set: dds_inc takes the held value the next cycle and inc_pend clears.
  - A value transferred in the same cycle as epoch_hit is not applied until the following epoch.
- Slew handshake:
  - Same rules as the increment handshake, with slew_ready = ~slew_pend.
  - A transferred slew_cnt of 0 is accepted and discarded; slew_pend is not set.
- State machine (two states, RUN and SLEW):
  - RUN -> SLEW on epoch_hit with slew_pend set. The next cycle, dds_enable=0, slewing=1, the remaining count is loaded from the held value, and slew_pend clears.
  - SLEW: the remaining count decrements each cycle. When it equals 1, dds_enable=1 and slewing=0 the next cycle, returning to RUN.
  - Net effect: dds_enable is low for exactly slew_cnt consecutive cycles.
  - No epoch_hit occurs in SLEW, since the DDS is frozen. Handshakes remain open during SLEW. Edge detection continues to run.
- Simultaneous pending increment and slew at an epoch: both are applied in the same cycle (new dds_inc and dds_enable=0 together).
- Latency: dds_msb rising edge -> chip_cnt and epoch change 1 cycle later -> DDS sees the new inc/enable on that same cycle.
- dds_inc width equals PHASE_INC_WIDTH; zero-extension is done inside the DDS.

Decomposition:
- Shared channel package holds:
  - the state encoding (RUN, SLEW);
  - CHIPS_PER_EPOCH_CA=1023;
  - default widths for phase increment, chip count and slew count.
- Natural sub-module: `hold_reg_hs`, a one-entry valid/ready holding register, instantiated twice (increment and slew).
- The DDS itself is instantiated by the channel top, not inside this block.

Test Plan:
1. Reset, then drive dds_msb as a square wave of period 8 with CHIPS_PER_EPOCH=4 -> chip_cnt cycles 0,1,2,3; epoch is high for one cycle every 32 cycles; dds_enable stays 1.
2. Push inc_in=0x000100 mid-epoch -> inc_ready drops; dds_inc becomes 0x000100 exactly one cycle after the next epoch_hit; inc_ready then rises.
3. Push slew_cnt=5 -> at the next epoch, dds_enable is low for exactly 5 cycles and slewing is high for the same 5 cycles; no epoch strobe occurs during them.
4. Increment and slew both pending at the same epoch -> dds_inc updates and dds_enable falls on the same cycle; both ready signals rise together.
5. Transfer inc on the exact epoch_hit cycle -> dds_inc is unchanged at this epoch and updates at the next one. Then push slew_cnt=0 -> no disable occurs, and slew_ready stays high.
6. Assert reset on the 2nd cycle of a 10-cycle slew -> next cycle dds_enable=1, slewing=0, chip_cnt=0, dds_inc=INC_RESET_VALUE, and both ready signals are high.

Source files
------------

// File: rtl/code_nco_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// code_nco_ctrl_pkg
//   Shared definitions for the tracking-channel code NCO controller.
//
//   Contents:
//     nco_state_e         controller state encoding (RUN / SLEW)
//     CHIPS_PER_EPOCH_CA  C/A code length in chips
//     *_WIDTH_DEF         default widths for increment, chip count, slew count
//     last_chip()         index of the final chip of an epoch at a given width
// ---------------------------------------------------------------------------
package code_nco_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SLEW = 1'b1
  } nco_state_e;

  localparam int CHIPS_PER_EPOCH_CA   = 1023;
  localparam int PHASE_INC_WIDTH_DEF  = 24;
  localparam int CHIP_CNT_WIDTH_DEF   = 10;
  localparam int SLEW_WIDTH_DEF       = 11;

  // Index of the last chip in an epoch, sized for a 32-bit compare; callers
  // cast it down to their own counter width.
  function automatic int last_chip(input int chips_per_epoch);
    return chips_per_epoch - 1;
  endfunction

endpackage

// File: rtl/code_nco_ctrl_hold_reg_hs.sv
// ---------------------------------------------------------------------------
// hold_reg_hs
//   One-entry valid/ready holding register. A word is accepted whenever the
//   register is empty and valid_i is high; it stays held (pend_o high) until
//   the consumer pulses take_i. When DROP_ZERO is set, an all-zero word is
//   still handshaken (ready_o was high) but is discarded instead of held.
//
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous, active-high reset (empties the register)
//     data_i   in   WIDTH   word offered by the producer
//     valid_i  in   1       data_i is valid
//     ready_o  out  1       register is empty and can accept a word
//     take_i   in   1       consumer takes the held word this cycle
//     pend_o   out  1       a word is held
//     data_o   out  WIDTH   held word
// ---------------------------------------------------------------------------
module hold_reg_hs #(
  parameter int WIDTH     = 8,
  parameter bit DROP_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             take_i,
  output logic             pend_o,
  output logic [WIDTH-1:0] data_o
);

  logic             pend_q, pend_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             xfer;
  logic             keep;

  assign ready_o = ~pend_q;
  assign pend_o  = pend_q;
  assign data_o  = data_q;

  assign xfer = valid_i & ~pend_q;
  // A zero word completes the handshake but is not worth holding.
  assign keep = ~(DROP_ZERO && (data_i == '0));

  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    // take_i and xfer cannot both act: xfer needs an empty register, and
    // the consumer only takes while the register is full.
    if (take_i) begin
      pend_d = 1'b0;
    end
    if (xfer && keep) begin
      pend_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/code_nco_ctrl.sv
// ---------------------------------------------------------------------------
// code_nco_ctrl
//   Sequencing controller for one tracking channel's code DDS. Counts code
//   chips from rising edges of the DDS MSB, strobes `epoch` once every
//   CHIPS_PER_EPOCH chips, and applies new code-rate increments and
//   code-phase slews (DDS freezes) only on epoch boundaries so that the
//   correlator accumulation intervals stay aligned with the code.
//
//   Ports:
//     clk         in   system clock
//     reset       in   synchronous, active-high reset
//     inc_in      in   PHASE_INC_WIDTH  new code-rate increment
//     inc_valid   in   inc_in is valid
//     inc_ready   out  increment holding register is free
//     slew_cnt    in   SLEW_WIDTH  number of clk cycles to freeze the DDS
//     slew_valid  in   slew_cnt is valid
//     slew_ready  out  slew holding register is free
//     dds_msb     in   MSB of the DDS output (chip clock)
//     dds_inc     out  PHASE_INC_WIDTH  increment driven to the DDS
//     dds_enable  out  DDS enable (low while slewing)
//     epoch       out  one-cycle strobe at each epoch boundary
//     chip_cnt    out  CHIP_CNT_WIDTH  chip index within the epoch
//     slewing     out  high while a slew is in progress
// ---------------------------------------------------------------------------
module code_nco_ctrl
  import code_nco_ctrl_pkg::*;
#(
  parameter int                         PHASE_INC_WIDTH = PHASE_INC_WIDTH_DEF,
  parameter int                         CHIPS_PER_EPOCH = CHIPS_PER_EPOCH_CA,
  parameter int                         CHIP_CNT_WIDTH  = CHIP_CNT_WIDTH_DEF,
  parameter int                         SLEW_WIDTH      = SLEW_WIDTH_DEF,
  parameter logic [PHASE_INC_WIDTH-1:0] INC_RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PHASE_INC_WIDTH-1:0] inc_in,
  input  logic                       inc_valid,
  output logic                       inc_ready,
  input  logic [SLEW_WIDTH-1:0]      slew_cnt,
  input  logic                       slew_valid,
  output logic                       slew_ready,
  input  logic                       dds_msb,
  output logic [PHASE_INC_WIDTH-1:0] dds_inc,
  output logic                       dds_enable,
  output logic                       epoch,
  output logic [CHIP_CNT_WIDTH-1:0]  chip_cnt,
  output logic                       slewing
);

  localparam logic [CHIP_CNT_WIDTH-1:0] LAST_CHIP =
    CHIP_CNT_WIDTH'(last_chip(CHIPS_PER_EPOCH));

  // ---- holding registers --------------------------------------------------
  logic                       inc_pend;
  logic [PHASE_INC_WIDTH-1:0] inc_held;
  logic                       inc_take;
  logic                       slew_pend;
  logic [SLEW_WIDTH-1:0]      slew_held;
  logic                       slew_take;

  hold_reg_hs #(
    .WIDTH     (PHASE_INC_WIDTH),
    .DROP_ZERO (1'b0)
  ) u_inc_hold (
    .clk     (clk),
    .reset   (reset),
    .data_i  (inc_in),
    .valid_i (inc_valid),
    .ready_o (inc_ready),
    .take_i  (inc_take),
    .pend_o  (inc_pend),
    .data_o  (inc_held)
  );

  // A zero-length slew would be a no-op freeze, so it is dropped on entry.
  hold_reg_hs #(
    .WIDTH     (SLEW_WIDTH),
    .DROP_ZERO (1'b1)
  ) u_slew_hold (
    .clk     (clk),
    .reset   (reset),
    .data_i  (slew_cnt),
    .valid_i (slew_valid),
    .ready_o (slew_ready),
    .take_i  (slew_take),
    .pend_o  (slew_pend),
    .data_o  (slew_held)
  );

  // ---- chip edge / epoch --------------------------------------------------
  logic                      msb_prev_q;
  logic [CHIP_CNT_WIDTH-1:0] chip_cnt_q, chip_cnt_d;
  logic                      epoch_q;
  logic                      chip_edge;
  logic                      epoch_hit;

  assign chip_edge = dds_msb & ~msb_prev_q;
  assign epoch_hit = chip_edge & (chip_cnt_q == LAST_CHIP);

  always_comb begin
    chip_cnt_d = chip_cnt_q;
    if (chip_edge) begin
      chip_cnt_d = (chip_cnt_q == LAST_CHIP) ? '0 : chip_cnt_q + 1'b1;
    end
  end

  // ---- RUN / SLEW state machine -------------------------------------------
  nco_state_e                 state_q, state_d;
  logic [SLEW_WIDTH-1:0]      slew_rem_q, slew_rem_d;
  logic [PHASE_INC_WIDTH-1:0] dds_inc_q, dds_inc_d;

  always_comb begin
    state_d    = state_q;
    slew_rem_d = slew_rem_q;
    dds_inc_d  = dds_inc_q;
    inc_take   = 1'b0;
    slew_take  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (epoch_hit && slew_pend) begin
          state_d    = ST_SLEW;
          slew_rem_d = slew_held;
          slew_take  = 1'b1;
        end
      end
      ST_SLEW: begin
        // The remaining count is N on the first frozen cycle and 1 on the
        // last, so the DDS sits disabled for exactly N cycles.
        slew_rem_d = slew_rem_q - 1'b1;
        if (slew_rem_q == SLEW_WIDTH'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Rate updates are independent of the slew path, so a pending increment
    // and a pending slew land on the same cycle.
    if (epoch_hit && inc_pend) begin
      dds_inc_d = inc_held;
      inc_take  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msb_prev_q <= 1'b0;
      chip_cnt_q <= '0;
      epoch_q    <= 1'b0;
      state_q    <= ST_RUN;
      slew_rem_q <= '0;
      dds_inc_q  <= INC_RESET_VALUE;
    end else begin
      msb_prev_q <= dds_msb;
      chip_cnt_q <= chip_cnt_d;
      epoch_q    <= epoch_hit;
      state_q    <= state_d;
      slew_rem_q <= slew_rem_d;
      dds_inc_q  <= dds_inc_d;
    end
  end

  // ---- outputs ------------------------------------------------------------
  assign dds_inc    = dds_inc_q;
  assign dds_enable = (state_q == ST_RUN);
  assign slewing    = (state_q == ST_SLEW);
  assign epoch      = epoch_q;
  assign chip_cnt   = chip_cnt_q;

endmodule

// File: tb/tb_code_nco_ctrl.sv
// ---------------------------------------------------------------------------
// tb_code_nco_ctrl
//   Directed bench for code_nco_ctrl with CHIPS_PER_EPOCH=4. A small chip
//   clock generator stands in for the DDS: its MSB has a period of 8 clk
//   cycles and it holds still while dds_enable is low.
// ---------------------------------------------------------------------------
module tb_code_nco_ctrl;

  localparam int PW  = 24;
  localparam int CW  = 10;
  localparam int SW  = 11;
  localparam int CPE = 4;
  localparam logic [PW-1:0] RST_INC = 24'h000ABC;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] inc_in;
  logic          inc_valid;
  logic          inc_ready;
  logic [SW-1:0] slew_cnt;
  logic          slew_valid;
  logic          slew_ready;
  logic          dds_msb;
  logic [PW-1:0] dds_inc;
  logic          dds_enable;
  logic          epoch;
  logic [CW-1:0] chip_cnt;
  logic          slewing;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] ph;
  logic       msb_last;
  logic       gen_on;

  always #5 clk = ~clk;

  code_nco_ctrl #(
    .PHASE_INC_WIDTH (PW),
    .CHIPS_PER_EPOCH (CPE),
    .CHIP_CNT_WIDTH  (CW),
    .SLEW_WIDTH      (SW),
    .INC_RESET_VALUE (RST_INC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inc_in     (inc_in),
    .inc_valid  (inc_valid),
    .inc_ready  (inc_ready),
    .slew_cnt   (slew_cnt),
    .slew_valid (slew_valid),
    .slew_ready (slew_ready),
    .dds_msb    (dds_msb),
    .dds_inc    (dds_inc),
    .dds_enable (dds_enable),
    .epoch      (epoch),
    .chip_cnt   (chip_cnt),
    .slewing    (slewing)
  );

  // Advance one clock; outputs are sampled 1 ns after the edge, then the
  // chip clock model steps (frozen while the DUT disables the DDS).
  task automatic tick();
    @(posedge clk);
    #1;
    msb_last = dds_msb;
    if (gen_on && dds_enable) ph = ph + 3'd1;
    dds_msb = ph[2];
  endtask

  task automatic wait_chip(input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (chip_cnt == CW'(v)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Runs until the epoch strobe; also returns the values seen the cycle before.
  task automatic wait_epoch(output bit ok, output logic [PW-1:0] p_inc,
                            output logic p_ir, output logic p_sr);
    ok    = 1'b0;
    p_inc = dds_inc;
    p_ir  = inc_ready;
    p_sr  = slew_ready;
    for (int i = 0; i < 300; i++) begin
      p_inc = dds_inc;
      p_ir  = inc_ready;
      p_sr  = slew_ready;
      tick();
      if (epoch === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inc_in = '0; inc_valid = 1'b0; slew_cnt = '0; slew_valid = 1'b0;
    gen_on = 1'b0; ph = '0; dds_msb = 1'b0; msb_last = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_checks++; if (dds_inc !== RST_INC) begin n_fail++; $display("FAIL reset_dds_inc: got %h expected %h", dds_inc, RST_INC); end
    n_checks++; if (dds_enable !== 1'b1) begin n_fail++; $display("FAIL reset_enable: got %b expected 1", dds_enable); end
    n_checks++; if (epoch !== 1'b0) begin n_fail++; $display("FAIL reset_epoch: got %b expected 0", epoch); end
    n_checks++; if (chip_cnt !== '0) begin n_fail++; $display("FAIL reset_chip_cnt: got %0d expected 0", chip_cnt); end
    n_checks++; if (slewing !== 1'b0) begin n_fail++; $display("FAIL reset_slewing: got %b expected 0", slewing); end
    n_checks++; if ({inc_ready, slew_ready} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b%b expected 11", inc_ready, slew_ready); end
    $display("test_reset done");
  endtask

  task automatic test_chip_count();
    int prev_cnt, last_ep, n_ep, low;
    logic prev_ep;
    gen_on = 1'b1;
    prev_cnt = 0; last_ep = -1; n_ep = 0; low = 0; prev_ep = 1'b0;
    for (int c = 0; c < 140; c++) begin
      tick();
      if (dds_enable !== 1'b1) low++;
      if (int'(chip_cnt) != prev_cnt) begin
        n_checks++;
        if (int'(chip_cnt) != (prev_cnt + 1) % CPE) begin
          n_fail++; $display("FAIL chip_step: got %0d expected %0d", chip_cnt, (prev_cnt + 1) % CPE);
        end
        prev_cnt = int'(chip_cnt);
      end
      if (epoch === 1'b1) begin
        n_ep++;
        n_checks++; if (chip_cnt !== '0) begin n_fail++; $display("FAIL epoch_chip: got %0d expected 0", chip_cnt); end
        n_checks++; if (prev_ep !== 1'b0) begin n_fail++; $display("FAIL epoch_width: got 2+ cycles expected 1"); end
        if (last_ep >= 0) begin
          n_checks++; if (c - last_ep != 32) begin n_fail++; $display("FAIL epoch_period: got %0d expected 32", c - last_ep); end
        end
        last_ep = c;
      end
      prev_ep = epoch;
    end
    n_checks++; if (n_ep < 4) begin n_fail++; $display("FAIL epoch_count: got %0d expected >=4", n_ep); end
    n_checks++; if (low != 0) begin n_fail++; $display("FAIL enable_run: got %0d low cycles expected 0", low); end
    $display("test_chip_count: %0d epochs", n_ep);
  endtask

  task automatic test_inc_update();
    bit ok; logic [PW-1:0] p_inc; logic p_ir, p_sr;
    wait_chip(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL inc_wait_chip: got timeout expected chip 1"); end
    inc_in = 24'h000100; inc_valid = 1'b1;
    tick();
    inc_valid = 1'b0;
    n_checks++; if (inc_ready !== 1'b0) begin n_fail++; $display("FAIL inc_ready_drop: got %b expected 0", inc_ready); end
    wait_epoch(ok, p_inc, p_ir, p_sr);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL inc_wait_epoch: got timeout expected epoch"); end
    n_checks++; if (p_inc !== RST_INC) begin n_fail++; $display("FAIL inc_before: got %h expected %h", p_inc, RST_INC); end
    n_checks++; if (p_ir !== 1'b0) begin n_fail++; $display("FAIL inc_ready_before: got %b expected 0", p_ir); end
    n_checks++; if (dds_inc !== 24'h000100) begin n_fail++; $display("FAIL inc_applied: got %h expected 000100", dds_inc); end
    n_checks++; if (inc_ready !== 1'b1) begin n_fail++; $display("FAIL inc_ready_rise: got %b expected 1", inc_ready); end
    $display("test_inc_update: dds_inc=%h", dds_inc);
  endtask

  task automatic test_slew();
    bit ok; logic [PW-1:0] p_inc; logic p_ir, p_sr;
    int low, bad;
    wait_chip(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL slew_wait_chip: got timeout expected chip 1"); end
    slew_cnt = 11'd5; slew_valid = 1'b1;
    tick();
    slew_valid = 1'b0;
    n_checks++; if (slew_ready !== 1'b0) begin n_fail++; $display("FAIL slew_ready_drop: got %b expected 0", slew_ready); end
    wait_epoch(ok, p_inc, p_ir, p_sr);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL slew_wait_epoch: got timeout expected epoch"); end
    n_checks++; if ({dds_enable, slewing} !== 2'b01) begin n_fail++; $display("FAIL slew_start: got en=%b sl=%b expected en=0 sl=1", dds_enable, slewing); end
    n_checks++; if ({p_sr, slew_ready} !== 2'b01) begin n_fail++; $display("FAIL slew_ready_rise: got %b->%b expected 0->1", p_sr, slew_ready); end
    low = 1; bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dds_enable === 1'b0) begin
        low++;
        if (slewing !== 1'b1) bad++;
        if (epoch !== 1'b0) bad++;
      end else break;
    end
    n_checks++; if (low != 5) begin n_fail++; $display("FAIL slew_len: got %0d expected 5", low); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL slew_flags: got %0d bad cycles expected 0", bad); end
    n_checks++; if (slewing !== 1'b0) begin n_fail++; $display("FAIL slew_end: got %b expected 0", slewing); end
    $display("test_slew: disabled %0d cycles", low);
  endtask

  task automatic test_inc_and_slew();
    bit ok; logic [PW-1:0] p_inc; logic p_ir, p_sr;
    int low;
    wait_chip(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL both_wait_chip: got timeout expected chip 1"); end
    inc_in = 24'h000200; slew_cnt = 11'd3; inc_valid = 1'b1; slew_valid = 1'b1;
    tick();
    inc_valid = 1'b0; slew_valid = 1'b0;
    n_checks++; if ({inc_ready, slew_ready} !== 2'b00) begin n_fail++; $display("FAIL both_ready_drop: got %b%b expected 00", inc_ready, slew_ready); end
    wait_epoch(ok, p_inc, p_ir, p_sr);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL both_wait_epoch: got timeout expected epoch"); end
    n_checks++; if (p_inc !== 24'h000100) begin n_fail++; $display("FAIL both_inc_before: got %h expected 000100", p_inc); end
    n_checks++; if (dds_inc !== 24'h000200) begin n_fail++; $display("FAIL both_inc: got %h expected 000200", dds_inc); end
    n_checks++; if (dds_enable !== 1'b0) begin n_fail++; $display("FAIL both_enable: got %b expected 0", dds_enable); end
    n_checks++; if ({p_ir, p_sr, inc_ready, slew_ready} !== 4'b0011) begin n_fail++; $display("FAIL both_ready_rise: got %b%b->%b%b expected 00->11", p_ir, p_sr, inc_ready, slew_ready); end
    low = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dds_enable === 1'b0) low++; else break;
    end
    n_checks++; if (low != 3) begin n_fail++; $display("FAIL both_slew_len: got %0d expected 3", low); end
    $display("test_inc_and_slew: dds_inc=%h disabled %0d cycles", dds_inc, low);
  endtask

  task automatic test_epoch_edge_xfer();
    bit ok; logic [PW-1:0] p_inc; logic p_ir, p_sr;
    int low;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (chip_cnt == CW'(CPE - 1) && dds_msb && !msb_last) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL edge_find_hit: got timeout expected hit"); end
    inc_in = 24'h000300; inc_valid = 1'b1;
    tick();
    inc_valid = 1'b0;
    n_checks++; if (epoch !== 1'b1) begin n_fail++; $display("FAIL edge_epoch: got %b expected 1", epoch); end
    n_checks++; if (dds_inc !== 24'h000200) begin n_fail++; $display("FAIL edge_inc_hold: got %h expected 000200", dds_inc); end
    n_checks++; if (inc_ready !== 1'b0) begin n_fail++; $display("FAIL edge_captured: got %b expected 0", inc_ready); end
    wait_epoch(ok, p_inc, p_ir, p_sr);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL edge_wait_epoch: got timeout expected epoch"); end
    n_checks++; if (dds_inc !== 24'h000300) begin n_fail++; $display("FAIL edge_inc_next: got %h expected 000300", dds_inc); end

    wait_chip(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_wait_chip: got timeout expected chip 1"); end
    slew_cnt = '0; slew_valid = 1'b1;
    tick();
    slew_valid = 1'b0;
    n_checks++; if (slew_ready !== 1'b1) begin n_fail++; $display("FAIL zero_slew_ready: got %b expected 1", slew_ready); end
    wait_epoch(ok, p_inc, p_ir, p_sr);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_wait_epoch: got timeout expected epoch"); end
    low = (dds_enable !== 1'b1 || slewing !== 1'b0) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dds_enable !== 1'b1 || slewing !== 1'b0) low++;
    end
    n_checks++; if (low != 0) begin n_fail++; $display("FAIL zero_slew_noop: got %0d disabled cycles expected 0", low); end
    $display("test_epoch_edge_xfer: dds_inc=%h", dds_inc);
  endtask

  task automatic test_reset_mid_slew();
    bit ok; logic [PW-1:0] p_inc; logic p_ir, p_sr;
    wait_chip(1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_wait_chip: got timeout expected chip 1"); end
    slew_cnt = 11'd10; slew_valid = 1'b1;
    tick();
    slew_valid = 1'b0;
    wait_epoch(ok, p_inc, p_ir, p_sr);
    n_checks++; if (!ok || dds_enable !== 1'b0) begin n_fail++; $display("FAIL rst_slew_start: got ok=%b en=%b expected ok=1 en=0", ok, dds_enable); end
    // Load both holding registers while frozen, then reset on the 2nd cycle.
    inc_in = 24'h000400; inc_valid = 1'b1; slew_cnt = 11'd7; slew_valid = 1'b1;
    tick();
    inc_valid = 1'b0; slew_valid = 1'b0;
    n_checks++; if ({dds_enable, inc_ready, slew_ready} !== 3'b000) begin n_fail++; $display("FAIL rst_pre: got en=%b ir=%b sr=%b expected 000", dds_enable, inc_ready, slew_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({dds_enable, slewing} !== 2'b10) begin n_fail++; $display("FAIL rst_abort: got en=%b sl=%b expected en=1 sl=0", dds_enable, slewing); end
    n_checks++; if (chip_cnt !== '0) begin n_fail++; $display("FAIL rst_chip: got %0d expected 0", chip_cnt); end
    n_checks++; if (dds_inc !== RST_INC) begin n_fail++; $display("FAIL rst_inc: got %h expected %h", dds_inc, RST_INC); end
    n_checks++; if ({inc_ready, slew_ready} !== 2'b11) begin n_fail++; $display("FAIL rst_ready: got %b%b expected 11", inc_ready, slew_ready); end
    // Nothing held before reset may surface at the next epoch.
    wait_epoch(ok, p_inc, p_ir, p_sr);
    n_checks++; if (!ok || dds_inc !== RST_INC || dds_enable !== 1'b1) begin n_fail++; $display("FAIL rst_flushed: got ok=%b inc=%h en=%b expected ok=1 inc=%h en=1", ok, dds_inc, dds_enable, RST_INC); end
    $display("test_reset_mid_slew done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_chip_count();
    test_inc_update();
    test_slew();
    test_inc_and_slew();
    test_epoch_edge_xfer();
    test_reset_mid_slew();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
